mod_reduce_stream: RTL

- Sequential, parametrised successor to the fixed 6-in/12-out modular lookup slices used in the mod-4051 datapath.
- Reduces an arbitrarily long operand, streamed MSB-chunk-first, to its residue modulo MODULUS.
- Uses a Horner bit-serial recurrence, so no per-position constant tables are needed; MODULUS, chunk width and maximum operand length are all parameters.
- Sits between the operand deserialiser and the residue-domain arithmetic units, one instance per residue channel.

---
 rtl/mod_reduce_pkg.sv | 27 ++
 rtl/mod_dbl_add_step.sv | 31 +++
 rtl/mod_reduce_stream.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mod_reduce_pkg.sv
// =============================================================================
// Module      : mod_reduce_pkg
// Description : Shared state encoding, default constants and width helper for
//               the streaming modular reducer.
// Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

package mod_reduce_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    localparam int MOD_4051   = 4051;
    localparam int RES_W_4051 = 12;
    localparam int CHUNK_DEF  = 6;

    function automatic int res_width(input int modulus);
        return (modulus < 2) ? 1 : $clog2(modulus);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mod_dbl_add_step.sv
// =============================================================================
// Module      : mod_dbl_add_step
// Description : One Horner step, result = (2*acc + b) mod MODULUS, for acc < M.
// Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

module mod_dbl_add_step
    import mod_reduce_pkg::*;
#(
    parameter int MODULUS = MOD_4051,
    parameter int W       = RES_W_4051
) (
    input  logic [W-1:0] acc,
    input  logic         b,
    output logic [W-1:0] result
);

    localparam logic [W:0] c_mod = (W+1)'(MODULUS);

    logic [W:0] w_t;

    // With acc < M the sum is at most 2M-1, so one subtraction is enough.
    always_comb begin
        w_t    = {acc, b};
        result = (w_t >= c_mod) ? W'(w_t - c_mod) : w_t[W-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/mod_reduce_stream.sv
// =============================================================================
// Module      : mod_reduce_stream
// Description : Bit-serial reduction of an MSB-first chunk stream modulo MODULUS.
// Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

module mod_reduce_stream
    import mod_reduce_pkg::*;
#(
    parameter int MODULUS    = MOD_4051,
    parameter int W          = res_width(MODULUS),
    parameter int CHUNK      = CHUNK_DEF,
    parameter int MAX_CHUNKS = 84,
    parameter int CW         = $clog2(MAX_CHUNKS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CHUNK-1:0] in_chunk,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_residue,
    output logic [CW-1:0]    out_nchunks,
    output logic             out_overflow
);

    localparam int            c_bw        = (CHUNK > 1) ? $clog2(CHUNK) : 1;
    localparam logic [c_bw-1:0] c_bit_top = c_bw'(CHUNK - 1);
    localparam logic [CW-1:0] c_max_count = CW'(MAX_CHUNKS);

    if (MODULUS < 2) begin : g_chk_modulus
        $error("mod_reduce_stream: MODULUS must be at least 2");
    end
    if (CHUNK < 1) begin : g_chk_chunk
        $error("mod_reduce_stream: CHUNK must be at least 1");
    end
    if (W < $clog2(MODULUS)) begin : g_chk_width
        $error("mod_reduce_stream: W too small for MODULUS");
    end

    state_t            state_q, state_d;
    logic [W-1:0]      acc_q, acc_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [CHUNK-1:0]  sreg_q, sreg_d;
    logic [c_bw-1:0]   bitcnt_q, bitcnt_d;
    logic              last_q, last_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [W-1:0]      out_residue_q, out_residue_d;
    logic [CW-1:0]     out_nchunks_q, out_nchunks_d;
    logic              out_overflow_q, out_overflow_d;
    logic [W-1:0]      w_step;

    mod_dbl_add_step #(
        .MODULUS (MODULUS),
        .W       (W)
    ) u_step (
        .acc    (acc_q),
        .b      (sreg_q[CHUNK-1]),
        .result (w_step)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        sreg_d   = sreg_q;
        bitcnt_d = bitcnt_q;
        last_d   = last_q;

        if (abort) begin
            state_d  = S_IDLE;
            acc_d    = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            sreg_d   = '0;
            bitcnt_d = '0;
            last_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        sreg_d   = in_chunk;
                        last_d   = in_last;
                        bitcnt_d = c_bit_top;
                        count_d  = (count_q == c_max_count) ? count_q : count_q + CW'(1);
                        ovf_d    = ovf_q | (count_q == c_max_count);
                        state_d  = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    acc_d    = w_step;
                    sreg_d   = sreg_q << 1;
                    bitcnt_d = bitcnt_q - c_bw'(1);
                    if (bitcnt_q == '0) begin
                        state_d = last_q ? S_OUT : S_IDLE;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        acc_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are registered from the next state so they line up with it.
        in_ready_d     = (state_d == S_IDLE);
        out_valid_d    = (state_d == S_OUT);
        out_residue_d  = out_valid_d ? acc_d   : '0;
        out_nchunks_d  = out_valid_d ? count_d : '0;
        out_overflow_d = out_valid_d & ovf_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            acc_q          <= '0;
            count_q        <= '0;
            ovf_q          <= 1'b0;
            sreg_q         <= '0;
            bitcnt_q       <= '0;
            last_q         <= 1'b0;
            in_ready_q     <= 1'b1;
            out_valid_q    <= 1'b0;
            out_residue_q  <= '0;
            out_nchunks_q  <= '0;
            out_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            count_q        <= count_d;
            ovf_q          <= ovf_d;
            sreg_q         <= sreg_d;
            bitcnt_q       <= bitcnt_d;
            last_q         <= last_d;
            in_ready_q     <= in_ready_d;
            out_valid_q    <= out_valid_d;
            out_residue_q  <= out_residue_d;
            out_nchunks_q  <= out_nchunks_d;
            out_overflow_q <= out_overflow_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_residue  = out_residue_q;
    assign out_nchunks  = out_nchunks_q;
    assign out_overflow = out_overflow_q;

endmodule

`default_nettype wire
